// File: rtl/mem_arbiter.sv
// Two-master (fetch / data) arbiter in front of a single-ported SRAM controller.
// Alternating priority on contention, latched request fields, and a grant watchdog.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no transaction; arbitrate between if_req and mem_req
//   GRANT_IF  | fetch read in flight, ram_req held high
//   GRANT_MEM | data-port read/write in flight, ram_req held high
//   RESP      | single cycle in which the completion valid is presented
module mem_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_done,
  output logic              busy,
  output logic              bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_MEM, RESP} state_t;

  state_t             r_state;
  logic               r_last_mem;
  logic [CW-1:0]      r_cnt;
  logic               w_pick_mem;
  logic               w_timeout;
  logic               w_finish;
  logic [DATA_W-1:0]  w_rdata;

  // On contention the data port wins unless it was served last.
  assign w_pick_mem = mem_req & (~if_req | ~r_last_mem);
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_finish   = ram_done | w_timeout;
  assign w_rdata    = ram_done ? ram_rdata : {DATA_W{1'b1}};
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_mem <= 1'b0;
      r_cnt      <= '0;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_valid   <= 1'b0;
      mem_valid  <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      bus_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req | if_req) begin
            ram_req <= 1'b1;
            r_cnt   <= '0;
            if (w_pick_mem) begin
              r_state    <= GRANT_MEM;
              r_last_mem <= 1'b1;
              ram_addr   <= mem_addr;
              ram_we     <= mem_we;
              if (mem_we) ram_wdata <= mem_wdata;
            end else begin
              r_state    <= GRANT_IF;
              r_last_mem <= 1'b0;
              ram_addr   <= if_addr;
              ram_we     <= 1'b0;
            end
          end
        end
        GRANT_IF, GRANT_MEM: begin
          if (w_finish) begin
            ram_req <= 1'b0;
            r_cnt   <= '0;
            r_state <= RESP;
            // ram_done beats a coincident watchdog expiry.
            if (!ram_done) bus_err <= 1'b1;
            if (r_state == GRANT_IF) begin
              if_valid <= 1'b1;
              if_rdata <= w_rdata;
            end else begin
              mem_valid <= 1'b1;
              if (!ram_we || !ram_done) mem_rdata <= w_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if_valid  <= 1'b0;
          mem_valid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: directed scenarios, then random traffic,
// with an SRAM responder and a transaction-level reference model.
module tb_mem_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_req, mem_we, ram_done;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata, ram_rdata;
  logic [DW-1:0] if_rdata, mem_rdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic          if_valid, mem_valid, ram_req, ram_we, busy, bus_err;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_done(ram_done), .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {bit port; logic [DW-1:0] data; bit err;} exp_t;
  typedef struct {bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} ram_t;

  exp_t sb[$];
  ram_t rq[$];
  int   dq[$];
  int   checks = 0;
  int   failures = 0;

  // reference model state
  bit            mdl_last_mem = 1'b0;
  bit            mdl_err = 1'b0;
  logic [DW-1:0] mdl_if_rd = '0;
  logic [DW-1:0] mdl_mem_rd = '0;
  logic [DW-1:0] mdl_mem [logic [AW-1:0]];
  // SRAM environment state
  logic [DW-1:0] sram [logic [AW-1:0]];
  bit            stray = 1'b0;

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One transaction, in grant order: what the SRAM should see and what the master gets back.
  task automatic predict(bit port, bit we, logic [AW-1:0] a, logic [DW-1:0] wd, int k);
    logic [DW-1:0] d;
    rq.push_back('{we, a, wd});
    dq.push_back(k);
    if (k > TO) begin
      d = '1;
      mdl_err = 1'b1;
    end else if (port && we) begin
      d = mdl_mem_rd;
      mdl_mem[a] = wd;
    end else begin
      d = mdl_mem.exists(a) ? mdl_mem[a] : init_val(a);
    end
    if (port) mdl_mem_rd = d; else mdl_if_rd = d;
    mdl_last_mem = port;
    sb.push_back('{port, d, mdl_err});
  endtask

  // SRAM responder: asserts ram_done on the k-th cycle of ram_req.
  int   rc = 0;
  int   rk = 0;
  bit   pend_chk = 1'b0;
  ram_t cur;
  always @(negedge clk) begin
    if (pend_chk) begin
      check("done_to_valid", {30'd0, ram_req, if_valid | mem_valid}, 32'd1);
      pend_chk = 1'b0;
    end
    ram_done = 1'b0;
    if (ram_req) begin
      rc++;
      if (rc == 1) begin
        if (rq.size() == 0) begin
          check("unexpected_ram_req", 32'd1, 32'd0);
          cur = '{1'b0, ram_addr, '0};
          rk = 1000;
        end else begin
          cur = rq.pop_front();
          rk = dq.pop_front();
          check("ram_we", {31'd0, ram_we}, {31'd0, cur.we});
          check("ram_addr", {14'd0, ram_addr}, {14'd0, cur.addr});
          if (cur.we) check("ram_wdata", {16'd0, ram_wdata}, {16'd0, cur.wdata});
        end
      end else if (ram_addr !== cur.addr) begin
        check("ram_addr_stable", {14'd0, ram_addr}, {14'd0, cur.addr});
      end
      if (rc > TO) check("ram_req_overrun", rc, TO);
      if (rc == rk) begin
        ram_done  = 1'b1;
        ram_rdata = sram.exists(cur.addr) ? sram[cur.addr] : init_val(cur.addr);
        if (cur.we) sram[cur.addr] = cur.wdata;
        pend_chk = 1'b1;
      end
    end else begin
      rc = 0;
      if (stray) begin
        ram_done  = 1'b1;
        ram_rdata = 16'hDEAD;
        stray = 1'b0;
      end
    end
  end

  // Monitor: every completion pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (if_valid && mem_valid) check("valids_exclusive", 32'd1, 32'd0);
      if (!busy && ram_req) check("ram_req_in_idle", 32'd1, 32'd0);
      if (if_valid || mem_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {30'd0, if_valid, mem_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("valid_port", {31'd0, mem_valid}, {31'd0, e.port});
          check("rdata", {16'd0, mem_valid ? mem_rdata : if_rdata}, {16'd0, e.data});
          check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done();
    int b = 0;
    while ((if_req || mem_req) && b < 300) begin
      @(negedge clk);
      if (if_valid) if_req = 1'b0;
      if (mem_valid) mem_req = 1'b0;
      b++;
    end
    if (if_req || mem_req) begin
      check("wait_done_budget", {30'd0, if_req, mem_req}, 32'd0);
      if_req = 1'b0;
      mem_req = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic wait_ram_req();
    int b = 0;
    while (!ram_req && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!ram_req) check("wait_ram_req_budget", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ram_req"}, {31'd0, ram_req}, 32'd0);
    check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_valids"}, {30'd0, if_valid, mem_valid}, 32'd0);
    check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ram_addr"}, {14'd0, ram_addr}, 32'd0);
    check({tag, "_ram_wdata"}, {16'd0, ram_wdata}, 32'd0);
    check({tag, "_rdata"}, {if_rdata, mem_rdata}, 32'd0);
  endtask

  task automatic model_reset();
    mdl_last_mem = 1'b0;
    mdl_err = 1'b0;
    mdl_if_rd = '0;
    mdl_mem_rd = '0;
  endtask

  initial begin
    int n_mem;
    rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; ram_done = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
    cyc(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc(1);

    // fetch read alone
    sram[18'h00010] = 16'h1234;
    mdl_mem[18'h00010] = 16'h1234;
    predict(1'b0, 1'b0, 18'h00010, '0, 3);
    if_addr = 18'h00010; if_req = 1'b1;
    wait_done();

    // contention: MEM write, IF read, then MEM (kept requesting) read back
    predict(1'b1, 1'b1, 18'h3FFFF, 16'hBEEF, 2);
    predict(1'b0, 1'b0, 18'h00000, '0, 4);
    predict(1'b1, 1'b0, 18'h3FFFF, '0, 1);
    mem_we = 1'b1; mem_addr = 18'h3FFFF; mem_wdata = 16'hBEEF; if_addr = '0;
    mem_req = 1'b1; if_req = 1'b1;
    n_mem = 0;
    for (int b = 0; b < 200 && (if_req || mem_req); b++) begin
      @(negedge clk);
      if (if_valid) if_req = 1'b0;
      if (mem_valid) begin
        n_mem++;
        if (n_mem == 1) mem_we = 1'b0; else mem_req = 1'b0;
      end
    end
    check("alternation_complete", {30'd0, if_req, mem_req}, 32'd0);
    if_req = 1'b0; mem_req = 1'b0;
    cyc(1);

    // latched address holds while the master changes its inputs
    predict(1'b1, 1'b0, 18'h00100, '0, 6);
    mem_we = 1'b0; mem_addr = 18'h00100; mem_req = 1'b1;
    wait_ram_req();
    mem_addr = 18'h00200; mem_we = 1'b1;
    wait_done();
    mem_we = 1'b0;

    // stray ram_done in IDLE, then done coincident with the last allowed cycle
    stray = 1'b1;
    cyc(3);
    predict(1'b0, 1'b0, 18'h00005, '0, TO);
    if_addr = 18'h00005; if_req = 1'b1;
    wait_done();
    check("no_err_on_coincident_done", {31'd0, bus_err}, 32'd0);

    // watchdog expiry, then error stays sticky over a good transaction
    predict(1'b1, 1'b0, 18'h00040, '0, 1000);
    mem_addr = 18'h00040; mem_req = 1'b1;
    wait_done();
    predict(1'b0, 1'b0, 18'h00041, '0, 2);
    if_addr = 18'h00041; if_req = 1'b1;
    wait_done();
    check("bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // reset in the middle of a grant
    rq.push_back('{1'b0, 18'h00055, '0});
    dq.push_back(1000);
    mem_addr = 18'h00055; mem_req = 1'b1;
    wait_ram_req();
    cyc(2);
    rst = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    check_reset_outputs("midgrant");
    rst = 1'b0;
    model_reset();
    stray = 1'b1;
    cyc(4);

    // random traffic
    for (int it = 0; it < 40; it++) begin
      int mode, ki, km;
      bit we;
      logic [AW-1:0] ai, am;
      logic [DW-1:0] wd;
      mode = $urandom_range(0, 2);
      ki = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(1, 8);
      km = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(1, 8);
      ai = AW'($urandom_range(0, 15));
      am = AW'($urandom_range(0, 15));
      we = $urandom_range(0, 1) != 0;
      wd = DW'($urandom);
      if (mode == 0) begin
        predict(1'b0, 1'b0, ai, '0, ki);
      end else if (mode == 1) begin
        predict(1'b1, we, am, wd, km);
      end else if (mdl_last_mem) begin
        predict(1'b0, 1'b0, ai, '0, ki);
        predict(1'b1, we, am, wd, km);
      end else begin
        predict(1'b1, we, am, wd, km);
        predict(1'b0, 1'b0, ai, '0, ki);
      end
      if_addr = ai; mem_addr = am; mem_we = we; mem_wdata = wd;
      if_req = (mode != 1);
      mem_req = (mode != 0);
      wait_done();
    end

    cyc(3);
    check("scoreboard_drained", sb.size(), 0);
    check("ram_queue_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
